stopwatch_tx_report_ctrl: RTL and testbench
===========================================

Name: stopwatch_tx_report_ctrl

Overview:
Sequences the UART transmit FIFO for the enhanced stopwatch. On a report request (the receive interface's tx start tick, from an "R"/"r" command), it snapshots the stopwatch digits and count direction. It then writes an ASCII status frame into the TX FIFO, one character per cycle, stalling whenever the FIFO is full. It sits between the stopwatch/receive interface and the TX FIFO write port.

Parameters:
NDIG, 4, number of BCD digits reported, MSB digit first; legal range 2-8.
DBIT, 8, FIFO word width; characters are 8-bit ASCII and the upper bits are zero when DBIT>8.

Ports:
i_clk  input  1  system clock, rising-edge
i_reset_n  input  1  asynchronous active-low reset
i_tx_start_tick  input  1  report request, one-cycle pulse
i_digits  input  4*NDIG  BCD digits; [4*NDIG-1:4*NDIG-4] is the most significant digit
i_up  input  1  stopwatch direction; 1=up, 0=down
i_tx_full  input  1  TX FIFO full flag
o_wr  output  1  TX FIFO write strobe
o_wr_data  output  DBIT  character being written
o_busy  output  1  frame in progress
o_done  output  1  one-cycle pulse after the last character of a frame is written

Behaviour:
- Reset (async, i_reset_n=0): state=IDLE; o_wr=0, o_busy=0, o_done=0; pending=0; snapshot and digit index cleared. Asserting reset mid-frame aborts immediately; no further writes occur, and the partial frame is not resumed.
- Frame, in order:
  - sign character: 0x2B '+' if i_up=1, 0x2D '-' if i_up=0
  - NDIG digit characters, MSB first, each 0x30+d
  - 0x0D (CR)
  - 0x0A (LF)
  - Total NDIG+3 characters.
- Digit rule: any digit value >9 is emitted as 0x3F '?'. Nothing else changes.
- Snapshot: i_digits and i_up are registered on the edge that accepts a request. Input changes during the frame do not affect it.
- States:
  - IDLE: accepts a tick and goes to SIGN.
  - SIGN: goes to DIGIT.
  - DIGIT: index runs 0..NDIG-1, then goes to CR.
  - CR: goes to LF.
  - LF: goes to DONE.
  - DONE: goes to SIGN if pending=1 (fresh snapshot, pending cleared), otherwise to IDLE.
- Write handshake:
  - In SIGN, DIGIT, CR and LF, o_wr = ~i_tx_full (combinational). o_wr_data is valid in the same cycle as o_wr.
  - The state or index advances only on an edge where o_wr=1.
  - If i_tx_full=1, the state holds and o_wr=0. o_wr_data holds its current character.
- Outside the emit states: o_wr=0 and o_wr_data=0.
- Latency: a tick sampled at edge k gives the first write in cycle k+1. With no stalls, the LF is written in cycle k+NDIG+3 and o_done=1 in cycle k+NDIG+4.
- o_busy=1 in every state except IDLE, including DONE.
- Tick while busy: sets pending. Any number of ticks during one frame queue exactly one extra frame. A tick in the DONE cycle also sets pending.
- A tick in IDLE is always accepted. It never writes in the acceptance cycle.

Optional Feature:
Macro STOPWATCH_TX_SEP_EN.
- Defined: a SEP state is inserted before the last digit, emitting 0x2E '.' (tenths separator). The frame becomes NDIG+4 characters and every subsequent latency grows by 1. SEP stalls on i_tx_full like every other emit state.
- Undefined: no SEP state, no '.' character, and the timing is exactly as stated in Behaviour.

Test Plan:
1. NDIG=4, i_digits=16'h1234, i_up=1, i_tx_full=0, tick -> writes 0x2B,0x31,0x32,0x33,0x34,0x0D,0x0A in 7 consecutive cycles; o_done one cycle after the LF write; o_busy deasserts the following cycle. With STOPWATCH_TX_SEP_EN: 0x2E appears between 0x33 and 0x34.
2. i_up=0, i_digits=16'h0A09 -> frame 0x2D,0x30,0x3F,0x30,0x39,0x0D,0x0A.
3. i_tx_full held 1 for 3 cycles during the second digit -> o_wr=0 for those 3 cycles; o_wr_data stays 0x32; the frame completes 3 cycles later with no character lost or duplicated.
4. Three ticks during a frame, with i_digits changed to 16'h5678 mid-frame -> the first frame is still 1234; exactly one following frame reports 5678; then IDLE.
5. i_reset_n pulsed low after the third write -> o_wr, o_busy and o_done drop asynchronously; after release, no writes occur until the next tick.
6. i_tx_full=1 when the tick arrives -> state SIGN with zero writes; on release, the full frame is written in order.

Source files
------------

// File: rtl/stopwatch_tx_report_ctrl.sv
// Writes the stopwatch status frame (sign, BCD digits, CR, LF) into the UART TX FIFO.
// Optional macro STOPWATCH_TX_SEP_EN inserts a '.' before the last digit.
module stopwatch_tx_report_ctrl #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned DBIT = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_tx_start_tick,
  input  logic [4*NDIG-1:0] i_digits,
  input  logic              i_up,
  input  logic              i_tx_full,
  output logic              o_wr,
  output logic [DBIT-1:0]   o_wr_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);
`ifdef STOPWATCH_TX_SEP_EN
  localparam logic [IW-1:0] SEP_IDX = IW'(NDIG - 2);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIGN,
    S_DIGIT,
`ifdef STOPWATCH_TX_SEP_EN
    S_SEP,
`endif
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_idx;
  logic [4*NDIG-1:0] r_digits;
  logic              r_up;
  logic              r_pending;
  logic              w_load;
  logic              w_emit;
  logic              w_adv;
  logic [3:0]        w_dig;
  logic [7:0]        w_char;

  // A new frame starts from IDLE or DONE on a tick or a queued request.
  assign w_load = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                  (i_tx_start_tick || r_pending);
  assign w_emit = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_adv  = w_emit && !i_tx_full;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load) w_next = S_SIGN;
      S_SIGN:  if (w_adv) w_next = S_DIGIT;
      S_DIGIT: begin
        if (w_adv) begin
          if (r_idx == LAST_IDX) w_next = S_CR;
`ifdef STOPWATCH_TX_SEP_EN
          else if (r_idx == SEP_IDX) w_next = S_SEP;
`endif
        end
      end
`ifdef STOPWATCH_TX_SEP_EN
      S_SEP:   if (w_adv) w_next = S_DIGIT;
`endif
      S_CR:    if (w_adv) w_next = S_LF;
      S_LF:    if (w_adv) w_next = S_DONE;
      S_DONE:  w_next = w_load ? S_SIGN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Snapshot, digit index and the single-deep request queue.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idx     <= '0;
      r_digits  <= '0;
      r_up      <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_load) begin
        r_idx     <= '0;
        r_digits  <= i_digits;
        r_up      <= i_up;
        r_pending <= 1'b0;
      end else begin
        if (i_tx_start_tick && (r_state != S_IDLE)) r_pending <= 1'b1;
        if ((r_state == S_DIGIT) && w_adv && (r_idx != LAST_IDX))
          r_idx <= r_idx + IW'(1);
      end
    end
  end

  always_comb begin
    w_dig = 4'h0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (r_idx == IW'(i)) w_dig = r_digits[4*(NDIG-1-i) +: 4];
    end
  end

  always_comb begin
    w_char = 8'h00;
    unique case (r_state)
      S_SIGN:  w_char = r_up ? 8'h2B : 8'h2D;
      S_DIGIT: w_char = (w_dig > 4'd9) ? 8'h3F : {4'h3, w_dig};
`ifdef STOPWATCH_TX_SEP_EN
      S_SEP:   w_char = 8'h2E;
`endif
      S_CR:    w_char = 8'h0D;
      S_LF:    w_char = 8'h0A;
      default: w_char = 8'h00;
    endcase
    o_wr      = w_adv;
    o_wr_data = DBIT'(w_char);
    o_busy    = (r_state != S_IDLE);
    o_done    = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_stopwatch_tx_report_ctrl.sv
// Bench for stopwatch_tx_report_ctrl: literal frame table, hand-written corner
// sequences and randomized stalls checked against a frame-level reference model.
module tb_stopwatch_tx_report_ctrl;
  localparam int unsigned NDIG = 4;
  localparam int unsigned DBIT = 8;
`ifdef STOPWATCH_TX_SEP_EN
  localparam int FLEN = NDIG + 4;
`else
  localparam int FLEN = NDIG + 3;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick;
  logic [4*NDIG-1:0] digits;
  logic              up;
  logic              full;
  logic              o_wr;
  logic [DBIT-1:0]   o_wr_data;
  logic              o_busy;
  logic              o_done;

  stopwatch_tx_report_ctrl #(.NDIG(NDIG), .DBIT(DBIT)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_tx_start_tick(tick), .i_digits(digits),
    .i_up(up), .i_tx_full(full), .o_wr(o_wr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] wq[$];
  int wc[$];
  int dq[$];
  logic [7:0] eq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done log plus per-cycle handshake sanity.
  always @(negedge clk) begin
    if (o_wr) begin
      wq.push_back(o_wr_data[7:0]);
      wc.push_back(cyc);
    end
    if (o_done) dq.push_back(cyc);
    checks++;
    if (o_wr && full) begin
      errors++;
      $display("FAIL wr_while_full: o_wr=%0b i_tx_full=%0b", o_wr, full);
    end
    if (!o_busy) begin
      checks++;
      if (o_wr || (o_wr_data != '0)) begin
        errors++;
        $display("FAIL idle_outputs: o_wr=%0b o_wr_data=%0h, want 0/0", o_wr, o_wr_data);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference frame straight from the character rules.
  function automatic void model(input logic [4*NDIG-1:0] dg, input logic u);
    int d;
    eq.delete();
    eq.push_back(u ? 8'h2B : 8'h2D);
    for (int i = 0; i < NDIG; i++) begin
      d = int'((dg / (32'd1 << (4 * (NDIG - 1 - i)))) % 16);
`ifdef STOPWATCH_TX_SEP_EN
      if (i == NDIG - 1) eq.push_back(8'h2E);
`endif
      eq.push_back((d > 9) ? 8'h3F : 8'(8'h30 + d));
    end
    eq.push_back(8'h0D);
    eq.push_back(8'h0A);
  endfunction

  task automatic cmp(input string nm, input int base);
    for (int i = 0; i < eq.size(); i++) begin
      if (base + i < wq.size()) chk(nm, wq[base+i], eq[i]);
      else                      chk(nm, 32'hFFFF, eq[i]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic clr();
    wq.delete(); wc.delete(); dq.delete();
  endtask

  task automatic wait_done(input int n, input int budget);
    int t = 0;
    while (dq.size() < n && t < budget) begin
      step(1);
      t++;
    end
    chk("done_timeout", dq.size(), n);
  endtask

  typedef struct {
    logic [15:0] dg;
    logic        u;
    logic [55:0] exp;
  } vec_t;
  vec_t tbl[5];

  int k;
  logic [15:0] rdg;
  logic        rup;

  initial begin
    tbl[0] = '{16'h1234, 1'b1, 56'h2B31323334_0D0A};
    tbl[1] = '{16'h0A09, 1'b0, 56'h2D303F3039_0D0A};
    tbl[2] = '{16'h9999, 1'b1, 56'h2B39393939_0D0A};
    tbl[3] = '{16'hFFF0, 1'b0, 56'h2D3F3F3F30_0D0A};
    tbl[4] = '{16'h0000, 1'b1, 56'h2B30303030_0D0A};

    rst_n = 1'b0; tick = 1'b0; digits = '0; up = 1'b0; full = 1'b0;
    step(3);
    chk("rst_wr", o_wr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_data", o_wr_data, 0);
    rst_n = 1'b1;
    step(2);

    // Literal frames with timing; inputs scrambled after acceptance.
    for (int v = 0; v < 5; v++) begin
      clr();
      digits = tbl[v].dg; up = tbl[v].u;
      pulse_tick();
      k = cyc;
      digits = ~tbl[v].dg; up = ~tbl[v].u;
      wait_done(1, 50);
      chk("tbl_busy_after", o_busy, 0);
      eq.delete();
      for (int b = 0; b < 7; b++) begin
`ifdef STOPWATCH_TX_SEP_EN
        if (b == NDIG) eq.push_back(8'h2E);
`endif
        eq.push_back(tbl[v].exp[55-8*b -: 8]);
      end
      chk("tbl_count", wq.size(), FLEN);
      cmp("tbl_char", 0);
      if (wc.size() == FLEN && dq.size() == 1) begin
        chk("tbl_first_cyc", wc[0], k);
        chk("tbl_last_cyc", wc[FLEN-1], k + FLEN - 1);
        chk("tbl_done_cyc", dq[0], k + FLEN);
      end
    end

    // Three-cycle stall on the second digit.
    clr();
    digits = 16'h1234; up = 1'b1;
    pulse_tick();
    k = cyc;
    step(2);
    full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_wr", o_wr, 0);
      chk("stall_data", o_wr_data, 8'h32);
      @(posedge clk); #1;
    end
    full = 1'b0;
    wait_done(1, 50);
    model(16'h1234, 1'b1);
    chk("stall_count", wq.size(), FLEN);
    cmp("stall_char", 0);
    if (dq.size() == 1) chk("stall_done_cyc", dq[0], k + FLEN + 3);

    // Ticks mid-frame queue exactly one more frame with a fresh snapshot.
    clr();
    digits = 16'h1234; up = 1'b1;
    pulse_tick();
    step(1);
    pulse_tick();
    digits = 16'h5678;
    pulse_tick();
    step(1);
    pulse_tick();
    wait_done(2, 60);
    step(FLEN + 4);
    chk("pend_count", wq.size(), 2 * FLEN);
    chk("pend_dones", dq.size(), 2);
    chk("pend_idle", o_busy, 0);
    model(16'h1234, 1'b1);
    cmp("pend_frame1", 0);
    model(16'h5678, 1'b1);
    cmp("pend_frame2", FLEN);
    if (dq.size() == 2) chk("pend_gap", dq[1] - dq[0], FLEN + 1);

    // Tick landing in the DONE cycle.
    clr();
    digits = 16'h4321; up = 1'b0;
    pulse_tick();
    k = 0;
    while (!o_done && k < 50) begin
      @(negedge clk);
      k++;
    end
    digits = 16'h8765; up = 1'b1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    wait_done(2, 60);
    step(2);
    chk("donetick_count", wq.size(), 2 * FLEN);
    model(16'h4321, 1'b0);
    cmp("donetick_frame1", 0);
    model(16'h8765, 1'b1);
    cmp("donetick_frame2", FLEN);

    // Reset mid-frame aborts at once and nothing resumes.
    clr();
    digits = 16'h1234; up = 1'b1;
    pulse_tick();
    step(3);
    rst_n = 1'b0;
    #1;
    chk("arst_wr", o_wr, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    step(2);
    rst_n = 1'b1;
    step(15);
    chk("arst_writes", wq.size(), 3);
    clr();
    pulse_tick();
    wait_done(1, 50);
    model(16'h1234, 1'b1);
    chk("arst_recover_count", wq.size(), FLEN);
    cmp("arst_recover", 0);

    // FIFO full when the request arrives.
    clr();
    digits = 16'h2468; up = 1'b0;
    full = 1'b1;
    pulse_tick();
    step(4);
    chk("fullstart_writes", wq.size(), 0);
    chk("fullstart_busy", o_busy, 1);
    chk("fullstart_wr", o_wr, 0);
    full = 1'b0;
    wait_done(1, 50);
    model(16'h2468, 1'b0);
    chk("fullstart_count", wq.size(), FLEN);
    cmp("fullstart_char", 0);

    // Random digits and random FIFO back-pressure.
    for (int r = 0; r < 30; r++) begin
      clr();
      rdg = 16'($urandom);
      rup = 1'($urandom_range(0, 1));
      digits = rdg; up = rup;
      pulse_tick();
      digits = 16'($urandom);
      k = 0;
      while (dq.size() == 0 && k < 300) begin
        full = ($urandom_range(0, 2) == 0);
        step(1);
        k++;
      end
      full = 1'b0;
      chk("rnd_done", dq.size(), 1);
      model(rdg, rup);
      chk("rnd_count", wq.size(), FLEN);
      cmp("rnd_char", 0);
      if (wc.size() == FLEN && dq.size() == 1) chk("rnd_done_cyc", dq[0], wc[FLEN-1] + 1);
      step(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
